madd_err_sweep_ctrl: RTL

Sequencer that drives an external combinational multiply-add unit (approximate or exact, `result = a*b + c`) through every operand combination and compares each result against an internal exact reference. It accumulates three error metrics: mismatch count, maximum absolute error and sum of absolute error. The block sits beside each approximate `madd` netlist in the error-evaluation harness, supplying its operand inputs and reading back its output bus.

---
 rtl/madd_eval_pkg.sv | 24 ++
 rtl/madd_exact_ref.sv | 17 +
 rtl/madd_err_sweep_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/madd_eval_pkg.sv
// Shared types and width helpers for the madd error-evaluation harness.
package madd_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_W     = 6;
    localparam int unsigned DEF_OUT_W = 12;

    // Mismatch counter must hold N = 2^(3W) itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return 3 * w + 1;
    endfunction

    // Sum of N errors, each at most 2^OUT_W - 1.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned out_w);
        return out_w + 3 * w;
    endfunction

endpackage

// File: rtl/madd_exact_ref.sv
// Combinational exact multiply-add reference: y = a*b + c truncated to OUT_W bits.
module madd_exact_ref #(
    parameter int unsigned W     = 6,
    parameter int unsigned OUT_W = 12
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    output logic [OUT_W-1:0] y
);

    // OUT_W >= 2W, so arithmetic at OUT_W bits equals the full-width result truncated.
    always_comb begin
        y = OUT_W'(a) * OUT_W'(b) + OUT_W'(c);
    end

endmodule

// File: rtl/madd_err_sweep_ctrl.sv
// Exhaustive operand sweep of an external multiply-add unit with a two-stage
// compare/accumulate pipeline producing mismatch count, max and sum of abs error.
module madd_err_sweep_ctrl
    import madd_eval_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    output logic [W-1:0]                     op_a,
    output logic [W-1:0]                     op_b,
    output logic [W-1:0]                     op_c,
    input  logic [OUT_W-1:0]                 dut_result,
    output logic                             busy,
    output logic                             done,
    output logic [cnt_width(W)-1:0]          err_count,
    output logic [OUT_W-1:0]                 err_max,
    output logic [sum_width(W, OUT_W)-1:0]   err_sum
);

    localparam int unsigned IDX_W = 3 * W;
    localparam int unsigned CNT_W = cnt_width(W);
    localparam int unsigned SUM_W = sum_width(W, OUT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               drain_q, drain_d;
    logic               s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]   s1_res_q, s1_res_d;
    logic [OUT_W-1:0]   s1_exact_q, s1_exact_d;
    logic [OUT_W-1:0]   s1_abs_q, s1_abs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   max_q, max_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [OUT_W-1:0]   exact;

    assign op_a = idx_q[3*W-1:2*W];
    assign op_b = idx_q[2*W-1:W];
    assign op_c = idx_q[W-1:0];

    madd_exact_ref #(
        .W     (W),
        .OUT_W (OUT_W)
    ) u_exact_ref (
        .a (op_a),
        .b (op_b),
        .c (op_c),
        .y (exact)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        s1_valid_d = 1'b0;
        s1_res_d   = dut_result;
        s1_exact_d = exact;
        s1_abs_d   = (exact > dut_result) ? (exact - dut_result) : (dut_result - exact);
        cnt_d      = cnt_q;
        max_d      = max_q;
        sum_d      = sum_q;

        if (s1_valid_q) begin
            if (s1_res_q != s1_exact_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (s1_abs_q > max_q) begin
                max_d = s1_abs_q;
            end
            sum_d = sum_q + SUM_W'(s1_abs_q);
        end

        // Abort and start both override the stage-2 update computed above.
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    drain_d = 1'b0;
                    cnt_d   = '0;
                    max_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                    max_d   = max_q;
                    sum_d   = sum_q;
                end else begin
                    s1_valid_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                    max_d   = max_q;
                    sum_d   = sum_q;
                end else if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_exact_q <= '0;
            s1_abs_q   <= '0;
            cnt_q      <= '0;
            max_q      <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_exact_q <= s1_exact_d;
            s1_abs_q   <= s1_abs_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign err_count = cnt_q;
    assign err_max   = max_q;
    assign err_sum   = sum_q;

endmodule
